// File: rtl/double_pulse.sv
// double_pulse: double-pulse test (DPT) gate-drive sequencer.
//
// A rising edge on TEM (after a 2-flop synchroniser and an edge register)
// launches one fixed K1 sequence: PULSE1 (T_ON1 cycles high), GAP (T_OFF
// cycles low) and PULSE2 (T_ON2 cycles high). The block then waits in DONE
// until TEM is released, so one press produces exactly one sequence.
//
// Optional feature, macro DP_SYNC_RECT_EN: when defined, the high-side gate
// K2 is driven inside GAP with DEAD cycles of dead time on both sides of the
// K1 edges. When undefined, K2 is constant 0.
//
// "enable" is the synchronous active-high reset of this block.

module double_pulse #(
  parameter int T_ON1 = 2000,
  parameter int T_OFF = 500,
  parameter int T_ON2 = 500,
  parameter int DEAD  = 10,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic enable,
  input  logic TEM,
  output logic K1,
  output logic K2
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE1 = 3'd1,
    GAP    = 3'd2,
    PULSE2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Down-counter reload values: a phase of length P runs P-1 .. 0.
  localparam logic [CNT_W-1:0] LD_ON1 = CNT_W'(T_ON1 - 1);
  localparam logic [CNT_W-1:0] LD_OFF = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] LD_ON2 = CNT_W'(T_ON2 - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             k1_reg;
  logic             k2_reg;

  // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3 (edge register).
  logic [2:0]       sync_reg;
  logic             tem_s2;
  logic             tem_rise;

  // K2 decisions, produced by the optional synchronous-rectification logic.
  logic             k2_start_next;  // K2 value on the PULSE1 -> GAP edge
  logic             k2_gap_next;    // K2 value on a non-final GAP edge

  assign tem_s2   = sync_reg[1];
  assign tem_rise = sync_reg[1] & ~sync_reg[2];

  // Synchronise TEM into clk and keep one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (enable) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], TEM};
    end
  end

`ifdef DP_SYNC_RECT_EN
  // K2 is only worth driving when the gap can hold two dead times.
  localparam bit             SR_OK      = (T_OFF > 2 * DEAD);
  localparam logic [CNT_W:0] K2_ON_IDX  = (CNT_W + 1)'(DEAD);
  localparam logic [CNT_W:0] K2_OFF_IDX = SR_OK ? (CNT_W + 1)'(T_OFF - DEAD)
                                                : '0;

  // Edges since K1 fell: the counter runs T_OFF-1 .. 0 in GAP, so the edge
  // being taken with count c is edge (T_OFF - c) after the falling edge.
  logic [CNT_W:0] gap_idx;
  assign gap_idx = (CNT_W + 1)'(T_OFF) - {1'b0, cnt_reg};

  // K2 high on edges DEAD .. T_OFF-DEAD-1 after K1 falls.
  assign k2_gap_next   = SR_OK && (gap_idx >= K2_ON_IDX) && (gap_idx < K2_OFF_IDX);
  assign k2_start_next = SR_OK && (DEAD == 0);
`else
  // High-side stays off; the freewheel diode carries current during GAP.
  assign k2_gap_next   = 1'b0;
  assign k2_start_next = 1'b0;

  // DEAD only matters when synchronous rectification is compiled in.
  logic unused_dead;
  assign unused_dead = (DEAD < 0);
`endif

  // Sequencer FSM with registered gate outputs.
  always_ff @(posedge clk) begin
    if (enable) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      k1_reg    <= 1'b0;
      k2_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          k1_reg <= 1'b0;
          k2_reg <= 1'b0;
          if (tem_rise) begin
            state_reg <= PULSE1;
            cnt_reg   <= LD_ON1;
            k1_reg    <= 1'b1;
          end
        end

        PULSE1: begin
          if (cnt_reg == '0) begin
            state_reg <= GAP;
            cnt_reg   <= LD_OFF;
            k1_reg    <= 1'b0;
            k2_reg    <= k2_start_next;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        GAP: begin
          if (cnt_reg == '0) begin
            state_reg <= PULSE2;
            cnt_reg   <= LD_ON2;
            k1_reg    <= 1'b1;
            k2_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            k2_reg  <= k2_gap_next;
          end
        end

        PULSE2: begin
          if (cnt_reg == '0) begin
            state_reg <= DONE;
            k1_reg    <= 1'b0;
            k2_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        DONE: begin
          k1_reg <= 1'b0;
          k2_reg <= 1'b0;
          // Re-arm only once TEM has been released.
          if (!tem_s2) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          k1_reg    <= 1'b0;
          k2_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign K1 = k1_reg;
  assign K2 = k2_reg;

endmodule

// File: tb/tb_double_pulse.sv
// tb_double_pulse: directed bench for double_pulse with a cycle model.
// The model tracks the sequence as an offset from its start edge and
// derives K1/K2 from the phase lengths.

module tb_double_pulse;

  localparam int T_ON1 = 4;
`ifdef DP_SYNC_RECT_EN
  localparam int T_OFF      = 8;
  localparam bit SR         = 1'b1;
  localparam int K2_PER_SEQ = 4;
`else
  localparam int T_OFF      = 3;
  localparam bit SR         = 1'b0;
  localparam int K2_PER_SEQ = 0;
`endif
  localparam int T_ON2 = 2;
  localparam int DEAD  = 2;
  localparam int CNT_W = 16;
  localparam int L_SEQ = T_ON1 + T_OFF + T_ON2;

  logic clk    = 1'b0;
  logic enable = 1'b1;
  logic TEM    = 1'b0;
  logic K1;
  logic K2;

  always #5 clk = ~clk;

  double_pulse #(
    .T_ON1(T_ON1),
    .T_OFF(T_OFF),
    .T_ON2(T_ON2),
    .DEAD (DEAD),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .enable(enable),
    .TEM   (TEM),
    .K1    (K1),
    .K2    (K2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: TEM history (samples 1, 2, 3 edges ago), mode
  // 0 = armed, 1 = sequence running, 2 = waiting for TEM release.
  bit h1 = 0, h2 = 0, h3 = 0;
  int mode   = 0;
  int n_edge = 0;
  int s_edge = 0;
  bit exp_k1 = 0;
  bit exp_k2 = 0;
  bit checking = 0;

  int   k1_hi = 0, k1_rise = 0, k2_hi = 0;
  logic k1_prev = 1'b0;

  task automatic model_step();
    bit rise;
    int j;
    rise = h2 & ~h3;
    n_edge++;
    if (enable) begin
      h1 = 0; h2 = 0; h3 = 0;
      mode = 0;
    end else begin
      case (mode)
        0: if (rise) begin mode = 1; s_edge = n_edge; end
        1: if (n_edge - s_edge == L_SEQ) mode = 2;
        default: if (!h2) mode = 0;
      endcase
      h3 = h2; h2 = h1; h1 = TEM;
    end
    j = n_edge - s_edge;
    exp_k1 = (mode == 1) && ((j < T_ON1) || (j >= T_ON1 + T_OFF));
    exp_k2 = SR && (T_OFF > 2 * DEAD) && (mode == 1) &&
             (j >= T_ON1 + DEAD) && (j < T_ON1 + T_OFF - DEAD);
  endtask

  // Per-cycle compare against the model, plus activity counters.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (checking) begin
        check("k1", K1, exp_k1);
        check("k2", K2, exp_k2);
        check("k1_k2_overlap", K1 & K2, 0);
        if (K1 === 1'b1) k1_hi++;
        if (K1 === 1'b1 && k1_prev !== 1'b1) k1_rise++;
        if (K2 === 1'b1) k2_hi++;
        k1_prev = K1;
      end
    end
  end

  initial begin
    int base_hi, base_k2, base_r;

    // Reset with TEM low.
    enable = 1'b1;
    TEM    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_k1", K1, 0);
    check("reset_k2", K2, 0);
    enable   = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);

    // Basic sequence: TEM held 50 ns, K1 rises on the third edge.
    base_hi = k1_hi;
    base_k2 = k2_hi;
    TEM = 1'b1;
    @(posedge clk); #1 check("lat_edge_n", K1, 0);
    @(posedge clk); #1 check("lat_edge_n1", K1, 0);
    @(posedge clk); #1 check("lat_edge_n2", K1, 1);
    repeat (3) @(negedge clk);
    TEM = 1'b0;
    repeat (25) @(negedge clk);
    check("basic_k1_cycles", k1_hi - base_hi, T_ON1 + T_ON2);
    check("basic_k2_cycles", k2_hi - base_k2, K2_PER_SEQ);

    // Retrigger: TEM toggled during PULSE1 changes nothing.
    base_r = k1_rise;
    TEM = 1'b1;
    repeat (3) @(negedge clk);
    TEM = 1'b0;
    @(negedge clk) TEM = 1'b1;
    @(negedge clk) TEM = 1'b0;
    repeat (25) @(negedge clk);
    check("retrig_rises", k1_rise - base_r, 2);

    // Held TEM: one double pulse, then one more after release and re-press.
    base_r = k1_rise;
    TEM = 1'b1;
    repeat (50) @(negedge clk);
    TEM = 1'b0;
    repeat (5) @(negedge clk);
    check("held_rises", k1_rise - base_r, 2);
    TEM = 1'b1;
    repeat (5) @(negedge clk);
    TEM = 1'b0;
    repeat (25) @(negedge clk);
    check("rearm_rises", k1_rise - base_r, 4);

    // Mid-sequence reset during GAP.
    TEM = 1'b1;
    repeat (3) @(negedge clk);
    TEM = 1'b0;
    repeat (T_ON1 + 1) @(negedge clk);
    check("gap_k1_low", K1, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("midrst_k1", K1, 0);
    check("midrst_k2", K2, 0);
    @(negedge clk);
    @(negedge clk) enable = 1'b0;
    base_r = k1_rise;
    base_hi = k1_hi;
    repeat (30) @(negedge clk);
    check("post_reset_rises", k1_rise - base_r, 0);
    check("post_reset_k1_cycles", k1_hi - base_hi, 0);

    // Fresh press after reset gives a full sequence again.
    base_r = k1_rise;
    base_hi = k1_hi;
    TEM = 1'b1;
    repeat (5) @(negedge clk);
    TEM = 1'b0;
    repeat (25) @(negedge clk);
    check("fresh_rises", k1_rise - base_r, 2);
    check("fresh_k1_cycles", k1_hi - base_hi, T_ON1 + T_ON2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
